// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-access sequencer and its step table.
package i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    SEL_DEV_W = 3'd0,
    SEL_REG   = 3'd1,
    SEL_WDATA = 3'd2,
    SEL_DEV_R = 3'd3,
    SEL_ONES  = 3'd4
  } byte_sel_e;

  typedef struct packed {
    logic      start;
    logic      wdata;
    logic      rdata;
    logic      stop;
    byte_sel_e byte_sel;
  } step_desc_t;

  localparam int WR_STEPS   = 3;
  localparam int RD_STEPS   = 4;
  localparam int RW_BIT_POS = 0;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic rw);
    logic [7:0] b;
    b = {dev, 1'b0};
    b[RW_BIT_POS] = rw;
    return b;
  endfunction

endpackage

// File: rtl/i2c_step_rom.sv
// Combinational map from (rw, step) to the byte-op descriptor for a single-register access.
module i2c_step_rom
  import i2c_pkg::*;
(
  input  logic       i_rw,
  input  logic [1:0] i_step,
  output step_desc_t o_desc
);

  always_comb begin
    o_desc = '{1'b0, 1'b0, 1'b0, 1'b0, SEL_ONES};
    case ({i_rw, i_step})
      3'b000:  o_desc = '{1'b1, 1'b1, 1'b0, 1'b0, SEL_DEV_W};
      3'b001:  o_desc = '{1'b0, 1'b1, 1'b0, 1'b0, SEL_REG};
      3'b010:  o_desc = '{1'b0, 1'b1, 1'b0, 1'b1, SEL_WDATA};
      3'b100:  o_desc = '{1'b1, 1'b1, 1'b0, 1'b0, SEL_DEV_W};
      3'b101:  o_desc = '{1'b0, 1'b1, 1'b0, 1'b0, SEL_REG};
      // repeated start turns the bus around for the read phase
      3'b110:  o_desc = '{1'b1, 1'b1, 1'b0, 1'b0, SEL_DEV_R};
      3'b111:  o_desc = '{1'b0, 1'b0, 1'b1, 1'b1, SEL_ONES};
      default: o_desc = '{1'b0, 1'b0, 1'b0, 1'b0, SEL_ONES};
    endcase
  end

endmodule

// File: rtl/i2c_reg_ctrl.sv
// Register read/write sequencer: splits one request into byte ops for the I2C byte engine
// and returns a single response with read data, NACK and timeout status.
module i2c_reg_ctrl
  import i2c_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned TO_W        = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_rw,
  input  logic [6:0] i_req_dev,
  input  logic [7:0] i_req_reg,
  input  logic [7:0] i_req_wdata,
  output logic       o_rsp_valid,
  input  logic       i_rsp_ready,
  output logic [7:0] o_rsp_rdata,
  output logic       o_rsp_nack,
  output logic       o_rsp_timeout,
  output logic       o_cmd_start,
  output logic       o_cmd_wdata,
  output logic       o_cmd_rdata,
  output logic       o_cmd_stop,
  output logic       o_wvalid,
  input  logic       i_wready,
  output logic [7:0] o_wdata,
  input  logic       i_byte_done,
  input  logic       i_ack,
  input  logic       i_rvalid,
  output logic       o_rready,
  input  logic [7:0] i_rdata,
  output logic       o_busy
);

  localparam logic [1:0]      WR_LAST = 2'(WR_STEPS - 1);
  localparam logic [1:0]      RD_LAST = 2'(RD_STEPS - 1);
  localparam logic            TO_EN   = (TIMEOUT_CYC != 32'd0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 32'd1);

  state_e          state_q, state_d;
  logic [1:0]      step_q, step_d;
  logic            rw_q, rw_d;
  logic [6:0]      dev_q, dev_d;
  logic [7:0]      reg_q, reg_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            nack_q, nack_d;
  logic            to_q, to_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            req_ready_q, req_ready_d;
  logic            wvalid_q, wvalid_d;
  logic            start_q, start_d;
  logic            cwdata_q, cwdata_d;
  logic            crdata_q, crdata_d;
  logic            stop_q, stop_d;
  logic [7:0]      obyte_q, obyte_d;
  logic            rready_q, rready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            is_last;
  logic            to_hit;
  logic            active;
  step_desc_t      desc_d;

  i2c_step_rom u_rom (
    .i_rw   (rw_d),
    .i_step (step_d),
    .o_desc (desc_d)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    rw_d    = rw_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    nack_d  = nack_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    is_last = (step_q == (rw_q ? RD_LAST : WR_LAST));
    to_hit  = TO_EN && (cnt_q == TO_LAST);
    case (state_q)
      ST_IDLE: begin
        if (i_req_valid && req_ready_q) begin
          rw_d    = i_req_rw;
          dev_d   = i_req_dev;
          reg_d   = i_req_reg;
          wdata_d = i_req_wdata;
          step_d  = 2'd0;
          rdata_d = 8'h00;
          nack_d  = 1'b0;
          to_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (wvalid_q && i_wready) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else if (to_hit) begin
          to_d    = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      ST_WAIT: begin
        if (i_rvalid && rready_q) begin
          rdata_d = i_rdata;
        end else begin
          rdata_d = rdata_q;
        end
        // a completing byte takes priority over a timeout landing in the same cycle
        if (i_byte_done) begin
          nack_d = nack_q | i_ack;
          if (is_last) begin
            state_d = ST_RESP;
          end else begin
            step_d  = step_q + 2'd1;
            state_d = ST_ISSUE;
          end
        end else if (to_hit) begin
          to_d    = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      ST_RESP: begin
        if (i_rsp_ready && rsp_valid_q) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with state_q.
  always_comb begin
    active      = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
    req_ready_d = (state_d == ST_IDLE);
    wvalid_d    = (state_d == ST_ISSUE);
    rsp_valid_d = (state_d == ST_RESP);
    rready_d    = (state_d == ST_WAIT) && desc_d.rdata;
    start_d     = active && desc_d.start;
    cwdata_d    = active && desc_d.wdata;
    crdata_d    = active && desc_d.rdata;
    stop_d      = active && desc_d.stop;
    obyte_d     = 8'h00;
    if (active) begin
      case (desc_d.byte_sel)
        SEL_DEV_W: obyte_d = addr_byte(dev_d, RW_WRITE);
        SEL_REG:   obyte_d = reg_d;
        SEL_WDATA: obyte_d = wdata_d;
        SEL_DEV_R: obyte_d = addr_byte(dev_d, RW_READ);
        SEL_ONES:  obyte_d = 8'hFF;
        default:   obyte_d = 8'h00;
      endcase
    end else begin
      obyte_d = 8'h00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      step_q      <= 2'd0;
      rw_q        <= 1'b0;
      dev_q       <= 7'h00;
      reg_q       <= 8'h00;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      nack_q      <= 1'b0;
      to_q        <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b0;
      wvalid_q    <= 1'b0;
      start_q     <= 1'b0;
      cwdata_q    <= 1'b0;
      crdata_q    <= 1'b0;
      stop_q      <= 1'b0;
      obyte_q     <= 8'h00;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      rw_q        <= rw_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      nack_q      <= nack_d;
      to_q        <= to_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      req_ready_q <= req_ready_d;
      wvalid_q    <= wvalid_d;
      start_q     <= start_d;
      cwdata_q    <= cwdata_d;
      crdata_q    <= crdata_d;
      stop_q      <= stop_d;
      obyte_q     <= obyte_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign o_req_ready   = req_ready_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_rdata   = rdata_q;
  assign o_rsp_nack    = nack_q;
  assign o_rsp_timeout = to_q;
  assign o_cmd_start   = start_q;
  assign o_cmd_wdata   = cwdata_q;
  assign o_cmd_rdata   = crdata_q;
  assign o_cmd_stop    = stop_q;
  assign o_wvalid      = wvalid_q;
  assign o_wdata       = obyte_q;
  assign o_rready      = rready_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Self-checking bench for i2c_reg_ctrl: an inline byte-engine model plus a reference op/response model.
module tb_i2c_reg_ctrl;

  localparam int TO_CYC = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_req_valid = 1'b0, i_req_rw = 1'b0;
  logic [6:0] i_req_dev = 7'h00;
  logic [7:0] i_req_reg = 8'h00, i_req_wdata = 8'h00;
  logic       i_rsp_ready = 1'b0, i_wready = 1'b0, i_byte_done = 1'b0, i_ack = 1'b0, i_rvalid = 1'b0;
  logic [7:0] i_rdata = 8'h00;
  logic       o_req_ready, o_rsp_valid, o_rsp_nack, o_rsp_timeout;
  logic       o_cmd_start, o_cmd_wdata, o_cmd_rdata, o_cmd_stop, o_wvalid, o_rready, o_busy;
  logic [7:0] o_rsp_rdata, o_wdata;

  i2c_reg_ctrl #(.TIMEOUT_CYC(TO_CYC), .TO_W(17)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_rw(i_req_rw),
    .i_req_dev(i_req_dev), .i_req_reg(i_req_reg), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_nack(o_rsp_nack), .o_rsp_timeout(o_rsp_timeout),
    .o_cmd_start(o_cmd_start), .o_cmd_wdata(o_cmd_wdata), .o_cmd_rdata(o_cmd_rdata),
    .o_cmd_stop(o_cmd_stop), .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata),
    .i_byte_done(i_byte_done), .i_ack(i_ack), .i_rvalid(i_rvalid), .o_rready(o_rready),
    .i_rdata(i_rdata), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // observations recorded by the engine model
  logic [7:0] obs_byte [8];
  logic [3:0] obs_flags[8];
  int         op_acc_cyc[8];
  int         obs_n, obs_err, obs_hung, accept_cyc, done_cyc, rsp_cyc;
  logic       obs_first_wvalid, obs_busy_acc, obs_nack, obs_to, obs_wv_rsp;
  logic [7:0] obs_rdata;

  // reference model
  logic [7:0] exp_byte [8];
  logic [3:0] exp_flags[8];
  int         exp_n;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [26:0] all_outs();
    return {o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_nack, o_rsp_timeout, o_cmd_start,
            o_cmd_wdata, o_cmd_rdata, o_cmd_stop, o_wvalid, o_wdata, o_rready, o_busy};
  endfunction

  // flags are {start, wdata, rdata, stop}
  task automatic model_build(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                             input logic [7:0] wd);
    exp_byte[0] = dev * 2;        exp_flags[0] = 4'b1100;
    exp_byte[1] = rg;             exp_flags[1] = 4'b0100;
    if (!rw) begin
      exp_n = 3;
      exp_byte[2] = wd;           exp_flags[2] = 4'b0101;
    end else begin
      exp_n = 4;
      exp_byte[2] = dev * 2 + 1;  exp_flags[2] = 4'b1100;
      exp_byte[3] = 8'hFF;        exp_flags[3] = 4'b0011;
    end
  endtask

  task automatic drive_txn(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd, input logic [3:0] nmask, input logic [7:0] rbyte,
                           input int stall_step, input int abort_step);
    int bound;
    int d;
    logic [3:0] fl;
    obs_n = 0; obs_err = 0; obs_hung = 0;
    i_req_rw = rw; i_req_dev = dev; i_req_reg = rg; i_req_wdata = wd; i_req_valid = 1'b1;
    bound = 0;
    while (!o_req_ready && bound < 100) begin tick(); bound++; end
    if (!o_req_ready) begin obs_hung = 1; i_req_valid = 1'b0; return; end
    tick();
    i_req_valid = 1'b0;
    accept_cyc = cyc; obs_first_wvalid = o_wvalid; obs_busy_acc = o_busy;
    for (int k = 0; k < 8; k++) begin
      bound = 0;
      while (!o_wvalid && !o_rsp_valid && bound < 200) begin tick(); bound++; end
      if (!o_wvalid) break;
      obs_byte[k] = o_wdata;
      fl = {o_cmd_start, o_cmd_wdata, o_cmd_rdata, o_cmd_stop};
      obs_flags[k] = fl;
      d = $urandom_range(0, 3);
      repeat (d) begin
        tick();
        if (!o_wvalid || o_wdata !== obs_byte[k] ||
            {o_cmd_start, o_cmd_wdata, o_cmd_rdata, o_cmd_stop} !== fl) obs_err++;
      end
      i_wready = 1'b1; tick(); i_wready = 1'b0;
      op_acc_cyc[k] = cyc; obs_n = k + 1;
      if (k == abort_step) return;
      if (k == stall_step) break;
      d = $urandom_range(0, 4);
      for (int j = 0; j <= d; j++) begin
        if (o_wvalid !== 1'b0 || o_wdata !== obs_byte[k] || o_rready !== fl[1] ||
            {o_cmd_start, o_cmd_wdata, o_cmd_rdata, o_cmd_stop} !== fl) obs_err++;
        if (j == d) begin
          i_byte_done = 1'b1;
          i_ack = (k < 4) ? nmask[k] : 1'b0;
          if (o_rready) begin i_rvalid = 1'b1; i_rdata = rbyte; end
          done_cyc = cyc;
        end
        tick();
      end
      i_byte_done = 1'b0; i_ack = 1'b0; i_rvalid = 1'b0; i_rdata = $urandom_range(0, 255);
    end
    bound = 0;
    while (!o_rsp_valid && bound < 200) begin tick(); bound++; end
    if (!o_rsp_valid) obs_hung = 1;
    rsp_cyc = cyc; obs_rdata = o_rsp_rdata; obs_nack = o_rsp_nack; obs_to = o_rsp_timeout;
    obs_wv_rsp = o_wvalid;
  endtask

  task automatic accept_rsp();
    repeat ($urandom_range(0, 2)) tick();
    i_rsp_ready = 1'b1; tick(); i_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    n_checks++;
    if (all_outs() !== 27'd0) begin n_fail++; $display("FAIL reset_outs: got %h want 0", all_outs()); end
    rst = 1'b0; tick();
    n_checks++;
    if ({o_req_ready, o_busy} !== 2'b10) begin
      n_fail++; $display("FAIL reset_ready: got rdy/busy %b want 10", {o_req_ready, o_busy});
    end
  endtask

  task automatic test_write();
    drive_txn(1'b0, 7'h50, 8'h10, 8'hA5, 4'h0, 8'h00, -1, -1);
    model_build(1'b0, 7'h50, 8'h10, 8'hA5);
    n_checks++;
    if (obs_n !== 3 || obs_hung !== 0) begin n_fail++; $display("FAIL write_nops: got %0d hung %0d want 3", obs_n, obs_hung); end
    for (int k = 0; k < exp_n; k++) begin
      n_checks++;
      if ({obs_flags[k], obs_byte[k]} !== {exp_flags[k], exp_byte[k]}) begin
        n_fail++; $display("FAIL write_op%0d: got %b/%h want %b/%h", k, obs_flags[k], obs_byte[k], exp_flags[k], exp_byte[k]);
      end
    end
    n_checks++;
    if ({obs_rdata, obs_nack, obs_to} !== {8'h00, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL write_rsp: got rd %h nack %b to %b want 00 0 0", obs_rdata, obs_nack, obs_to);
    end
    n_checks++;
    if (obs_first_wvalid !== 1'b1 || obs_busy_acc !== 1'b1 || rsp_cyc - done_cyc !== 1) begin
      n_fail++; $display("FAIL write_latency: got wv %b busy %b rsp-done %0d want 1 1 1", obs_first_wvalid, obs_busy_acc, rsp_cyc - done_cyc);
    end
    n_checks++;
    if (obs_err !== 0) begin n_fail++; $display("FAIL write_stable: got %0d errors want 0", obs_err); end
    accept_rsp();
    n_checks++;
    if ({o_req_ready, o_busy, o_rsp_valid} !== 3'b100) begin
      n_fail++; $display("FAIL write_idle: got %b want 100", {o_req_ready, o_busy, o_rsp_valid});
    end
  endtask

  task automatic test_read();
    drive_txn(1'b1, 7'h50, 8'h22, 8'h77, 4'h0, 8'h3C, -1, -1);
    model_build(1'b1, 7'h50, 8'h22, 8'h77);
    n_checks++;
    if (obs_n !== 4 || obs_hung !== 0) begin n_fail++; $display("FAIL read_nops: got %0d hung %0d want 4", obs_n, obs_hung); end
    for (int k = 0; k < exp_n; k++) begin
      n_checks++;
      if ({obs_flags[k], obs_byte[k]} !== {exp_flags[k], exp_byte[k]}) begin
        n_fail++; $display("FAIL read_op%0d: got %b/%h want %b/%h", k, obs_flags[k], obs_byte[k], exp_flags[k], exp_byte[k]);
      end
    end
    n_checks++;
    if ({obs_rdata, obs_nack, obs_to} !== {8'h3C, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL read_rsp: got rd %h nack %b to %b want 3c 0 0", obs_rdata, obs_nack, obs_to);
    end
    n_checks++;
    if (obs_err !== 0) begin n_fail++; $display("FAIL read_stable: got %0d errors want 0", obs_err); end
    accept_rsp();
  endtask

  task automatic test_nack();
    drive_txn(1'b0, 7'h2A, 8'h05, 8'h5A, 4'b0001, 8'h00, -1, -1);
    model_build(1'b0, 7'h2A, 8'h05, 8'h5A);
    n_checks++;
    if (obs_n !== exp_n || obs_flags[2] !== exp_flags[2]) begin
      n_fail++; $display("FAIL nack_ops: got n %0d last %b want %0d %b", obs_n, obs_flags[2], exp_n, exp_flags[2]);
    end
    n_checks++;
    if ({obs_nack, obs_to} !== 2'b10) begin n_fail++; $display("FAIL nack_rsp: got nack/to %b want 10", {obs_nack, obs_to}); end
    accept_rsp();
  endtask

  task automatic test_timeout();
    drive_txn(1'b0, 7'h11, 8'h33, 8'h44, 4'h0, 8'h00, 1, -1);
    n_checks++;
    if (obs_n !== 2 || obs_hung !== 0) begin n_fail++; $display("FAIL to_nops: got %0d hung %0d want 2", obs_n, obs_hung); end
    n_checks++;
    if (rsp_cyc - op_acc_cyc[1] !== TO_CYC) begin
      n_fail++; $display("FAIL to_delay: got %0d cycles want %0d", rsp_cyc - op_acc_cyc[1], TO_CYC);
    end
    n_checks++;
    if ({obs_to, obs_nack, obs_wv_rsp} !== 3'b100) begin
      n_fail++; $display("FAIL to_rsp: got to/nack/wv %b want 100", {obs_to, obs_nack, obs_wv_rsp});
    end
    accept_rsp();
    n_checks++;
    if ({o_busy, o_req_ready} !== 2'b01) begin n_fail++; $display("FAIL to_release: got busy/rdy %b want 01", {o_busy, o_req_ready}); end
  endtask

  task automatic test_backpressure();
    logic [9:0] snap;
    logic [3:0] nm;
    nm = 4'($urandom_range(0, 15));
    drive_txn(1'b1, 7'($urandom_range(0, 127)), 8'h40, 8'h00, nm, 8'hC3, -1, -1);
    snap = {obs_rdata, obs_nack, obs_to};
    n_checks++;
    if (snap !== {8'hC3, |nm, 1'b0}) begin n_fail++; $display("FAIL bp_rsp: got %h want %h", snap, {8'hC3, |nm, 1'b0}); end
    i_req_valid = 1'b1; i_req_rw = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_checks++;
      if ({o_rsp_valid, o_rsp_rdata, o_rsp_nack, o_rsp_timeout, o_req_ready, o_wvalid, o_busy} !== {1'b1, snap, 3'b001}) begin
        n_fail++; $display("FAIL bp_hold%0d: got %h want %h", c,
          {o_rsp_valid, o_rsp_rdata, o_rsp_nack, o_rsp_timeout, o_req_ready, o_wvalid, o_busy}, {1'b1, snap, 3'b001});
      end
    end
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b1; tick(); i_rsp_ready = 1'b0;
    n_checks++;
    if ({o_req_ready, o_rsp_valid, o_busy, o_wvalid} !== 4'b1000) begin
      n_fail++; $display("FAIL bp_release: got %b want 1000", {o_req_ready, o_rsp_valid, o_busy, o_wvalid});
    end
  endtask

  task automatic test_reset_mid();
    drive_txn(1'b1, 7'h50, 8'h22, 8'h00, 4'h0, 8'h3C, -1, 2);
    n_checks++;
    if (obs_n !== 3) begin n_fail++; $display("FAIL rstmid_reach: got %0d ops want 3", obs_n); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (all_outs() !== 27'd0) begin n_fail++; $display("FAIL rstmid_outs: got %h want 0", all_outs()); end
    tick(); tick();
    rst = 1'b0;
    tick();
    drive_txn(1'b1, 7'h3B, 8'h9E, 8'h00, 4'h0, 8'h81, -1, -1);
    model_build(1'b1, 7'h3B, 8'h9E, 8'h00);
    n_checks++;
    if (obs_n !== exp_n || {obs_flags[0], obs_byte[0]} !== {exp_flags[0], exp_byte[0]}) begin
      n_fail++; $display("FAIL rstmid_restart: got n %0d op0 %b/%h want %0d %b/%h", obs_n, obs_flags[0], obs_byte[0], exp_n, exp_flags[0], exp_byte[0]);
    end
    n_checks++;
    if ({obs_rdata, obs_nack, obs_to} !== {8'h81, 2'b00}) begin
      n_fail++; $display("FAIL rstmid_rsp: got %h want 810", {obs_rdata, obs_nack, obs_to});
    end
    accept_rsp();
  endtask

  task automatic test_random();
    logic rw;
    logic [6:0] dev;
    logic [7:0] rg, wd, rb;
    logic [3:0] nm;
    logic exp_nack;
    for (int t = 0; t < 24; t++) begin
      rw = 1'($urandom_range(0, 1)); dev = 7'($urandom_range(0, 127));
      rg = 8'($urandom_range(0, 255)); wd = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255));
      nm = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      drive_txn(rw, dev, rg, wd, nm, rb, -1, -1);
      model_build(rw, dev, rg, wd);
      exp_nack = 1'b0;
      for (int k = 0; k < exp_n; k++) if (nm[k]) exp_nack = 1'b1;
      n_checks++;
      if (obs_n !== exp_n || obs_hung !== 0 || obs_err !== 0) begin
        n_fail++; $display("FAIL rand%0d_seq: got n %0d hung %0d err %0d want %0d 0 0", t, obs_n, obs_hung, obs_err, exp_n);
      end
      for (int k = 0; k < exp_n; k++) begin
        n_checks++;
        if ({obs_flags[k], obs_byte[k]} !== {exp_flags[k], exp_byte[k]}) begin
          n_fail++; $display("FAIL rand%0d_op%0d: got %b/%h want %b/%h", t, k, obs_flags[k], obs_byte[k], exp_flags[k], exp_byte[k]);
        end
      end
      n_checks++;
      if ({obs_rdata, obs_nack, obs_to} !== {(rw ? rb : 8'h00), exp_nack, 1'b0}) begin
        n_fail++; $display("FAIL rand%0d_rsp: got %h want %h", t, {obs_rdata, obs_nack, obs_to}, {(rw ? rb : 8'h00), exp_nack, 1'b0});
      end
      accept_rsp();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_reg_ctrl.md
Name: i2c_reg_ctrl

Overview:
- Register-access sequencer that sits directly upstream of the team's 8-bit I2C byte engine.
- Accepts one register read or write request (7-bit device address, 8-bit register address, 8-bit data) and breaks it into a fixed sequence of byte operations, each with start/write/read/stop flags.
- Collects the slave ACK status and read data, and returns one response per request.

Parameters:
- TIMEOUT_CYC, 100000: maximum clk cycles to wait for one byte operation to complete; 0 disables the timeout.
- TO_W, 17: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request accepted when valid&ready
- i_req_rw  in  1  0=write, 1=read
- i_req_dev  in  7  7-bit slave address
- i_req_reg  in  8  register address
- i_req_wdata  in  8  write data (ignored for reads)
- o_rsp_valid  out  1  response valid, held until accepted
- i_rsp_ready  in  1  response accept
- o_rsp_rdata  out  8  read data (0 for writes)
- o_rsp_nack  out  1  at least one byte was NACKed
- o_rsp_timeout  out  1  sequence aborted by timeout
- o_cmd_start, o_cmd_wdata, o_cmd_rdata, o_cmd_stop  out  1 each  byte-op flags to engine
- o_wvalid  out  1  byte-op request to engine
- i_wready  in  1  engine accepts the byte op
- o_wdata  out  8  byte to transmit
- i_byte_done  in  1  one-cycle pulse: current byte op (incl. start/stop) finished
- i_ack  in  1  engine NACK flag (1 = slave did not acknowledge), sampled on i_byte_done
- i_rvalid  in  1  read byte valid
- o_rready  out  1  read byte accept
- i_rdata  in  8  read byte
- o_busy  out  1  high from request accept until response accepted

Behaviour:
- Reset: every output is 0; the state machine enters IDLE and step, timeout counter and latched fields clear. Asserting rst mid-sequence aborts immediately. No response is produced for the aborted request, and bus recovery is the engine's responsibility.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid: latch rw/dev/reg/wdata, clear step, nack and timeout flags, set o_busy, then go to ISSUE.
- Write sequence (3 steps):
  - step 0: start+wdata, byte {dev,0}
  - step 1: wdata, byte reg
  - step 2: wdata+stop, byte wdata
- Read sequence (4 steps):
  - step 0: start+wdata, byte {dev,0}
  - step 1: wdata, byte reg
  - step 2: start+wdata, byte {dev,1} (repeated start)
  - step 3: rdata+stop, o_wdata=0xFF
- ISSUE:
  - o_wvalid=1; the cmd flags and o_wdata are decoded from the current step.
  - On o_wvalid&i_wready, clear the timeout counter and go to WAIT.
- WAIT:
  - o_wvalid=0, but the cmd flags and o_wdata stay stable until i_byte_done; the engine samples them throughout the op.
  - o_rready=1 only during the read step.
  - i_rvalid&o_rready captures i_rdata into o_rsp_rdata.
  - On i_byte_done, OR i_ack into the nack flag. If this is the last step go to RESP, else increment step and go to ISSUE (no idle cycle).
- NACK does not abort the sequence: all steps always run, so the stop is always issued and the bus is released.
- Timeout (TIMEOUT_CYC≠0):
  - The counter runs in ISSUE and WAIT and clears on each accepted byte op.
  - When it reaches TIMEOUT_CYC: drop o_wvalid, set o_rsp_timeout, go to RESP.
  - If i_byte_done and timeout expiry land in the same cycle, done wins.
- RESP:
  - o_rsp_valid=1, with rdata/nack/timeout held stable.
  - On i_rsp_ready, clear o_busy and go to IDLE. o_req_ready reasserts the next cycle; requests are never accepted back-to-back in the same cycle.
- A read byte arriving after i_byte_done is not captured; the engine must present it before or with i_byte_done.
- Latency: request accept to first o_wvalid is 1 cycle; last i_byte_done to o_rsp_valid is 1 cycle.

Decomposition:
- Shared package i2c_pkg holds:
  - state encodings
  - the step-descriptor type {start, wdata, rdata, stop, byte_sel}
  - constants WR_STEPS=3 and RD_STEPS=4
  - the R/W bit positions
- One natural sub-module, i2c_step_rom: a combinational map from (rw, step) to the step descriptor, shared with future multi-byte sequencers.
- Timeout counter stays inline.

Test Plan:
- Write dev=0x50, reg=0x10, data=0xA5, with a model engine that ACKs all → exactly 3 ops:
  - 0xA0 with start+wdata
  - 0x10 with wdata
  - 0xA5 with wdata+stop
  - then rsp_valid with nack=0, timeout=0, rdata=0x00.
- Read dev=0x50, reg=0x22, engine returns 0x3C → 4 ops: 0xA0, 0x22, 0xA1 (start), then rdata+stop. Response rdata=0x3C, nack=0.
- Write with the engine flagging NACK on step 0 → all 3 ops are still issued, stop is present, rsp nack=1.
- TIMEOUT_CYC=50, engine never pulses i_byte_done after step 1 accept → rsp timeout=1 exactly 50 cycles after the accept, o_wvalid=0, busy clears on rsp_ready.
- Response backpressure: hold i_rsp_ready=0 for 20 cycles → rsp fields stable, o_req_ready=0, no new ops issued; release → IDLE next cycle.
- Assert rst during WAIT of read step 2 → all outputs 0 within the same cycle; the next request runs cleanly from step 0.
